nios2_fetch: RTL and testbench
==============================

Name: nios2_fetch

Overview:
Instruction fetch stage sitting directly upstream of the nios2 core. It drives the core's instruction18 input.
- Holds the fetch PC and issues sequential word reads to a synchronous instruction memory (1-cycle read latency).
- Buffers returned words with their PC in a 2-entry queue and presents them to the core under a valid/stall handshake.
- Accepts PC redirects (taken branch, br, reset vector) from the core and discards wrong-path words.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset; must be word aligned
ADDR_W, 32, width of PC and memory address (PC arithmetic is modulo 2^ADDR_W)

Ports:
clk18  in  1  single clock; all state updates on rising edge
rst18  in  1  asynchronous, active-high reset
imem_rd18  out  1  memory read strobe, one word per asserted cycle
imem_addr18  out  ADDR_W  byte address of the read; bits [1:0] always 0
imem_rdata18  in  32  read data, valid exactly one cycle after the cycle imem_rd18 was high
stall18  in  1  core cannot accept an instruction this cycle
redirect18  in  1  core requests fetch from a new PC
redirect_pc18  in  ADDR_W  new fetch PC; bits [1:0] are ignored (forced to 0)
valid18  out  1  instruction18/pc18 hold a live instruction
instruction18  out  32  instruction word to the core; NOP (32'h0001883A) when valid18=0
pc18  out  ADDR_W  address of instruction18

Behaviour:
- Reset (async, rst18=1) forces the following; the memory-response kill flag is cleared.
  - fetch_pc=RESET_PC, queue empty, in-flight=0.
  - imem_rd18=0, valid18=0, instruction18=NOP, pc18=RESET_PC.
- Reset mid-operation discards all queued and in-flight words. A memory response arriving in the first cycle after reset release is ignored.
- pop = valid18 & ~stall18 & ~redirect18. The head entry is consumed on pop.
- Issue rule: imem_rd18 = ~redirect18 & (occupancy + inflight - pop < 2).
  - On issue: imem_addr18 = fetch_pc, fetch_pc <= fetch_pc + 4, inflight <= 1.
  - fetch_pc wraps from 2^ADDR_W-4 to 0.
- Response: in the cycle after an issue, imem_rdata18 is pushed into the queue tagged with its address, unless the kill flag is set.
  - The issue rule guarantees the queue never overflows. Push and pop in the same cycle are legal.
- Output: instruction18/pc18/valid18 come combinationally from the queue head register (registered data, no memory-to-core path). valid18 = ~empty.
- Stall: while stall18=1 the head is held stable and no new issue occurs once occupancy + inflight = 2.
- Redirect (takes priority over stall and pop):
  - The queue is flushed.
  - Any in-flight response is marked killed.
  - fetch_pc <= {redirect_pc18[ADDR_W-1:2], 2'b00}.
  - imem_rd18=0 in the redirect cycle.
  - First read of the target is issued in the next cycle; the target instruction is valid 2 cycles after the redirect edge.
  - Back-to-back redirects: the last one wins.
- Latency: first imem_rd18 occurs in the first cycle after reset release. First valid18 comes 2 cycles after reset release.
- Throughput: 1 instruction/cycle sustained with stall18=0.

Decomposition:
- nios2_pkg holds: NIOS2_NOP=32'h0001883A, INSTR_W=32, default RESET_PC, opcode constants (BR=6'h06, BLT=6'h16, LDW=6'h17, STW=6'h15) shared with the core.
- Sub-module nios2_fetch_fifo: 2-entry {pc,instr} queue with push/pop/flush, occupancy count and head outputs.
- The top level holds the PC, issue logic, in-flight/kill flags and output muxing.

Test Plan:
- Reset release, memory word0=32'h21000017, word4=32'h000A0C7A, stall18=0 -> imem_addr18 0,4,8,... one per cycle; valid18 rises 2 cycles after release; pc18=0/instruction18=32'h21000017, then pc18=4/32'h000A0C7A.
- Stall18=1 for 3 cycles while pc18=4 -> instruction18 stays 32'h000A0C7A; imem_rd18 drops after 2 outstanding; after release, pc18 continues 8,12 with no gap or duplicate.
- Redirect18 with redirect_pc18=32'h0000_0010 while 2 words are queued/in flight -> valid18=0 next cycle; killed response never appears; pc18=0x10 valid 2 cycles later.
- Redirect with redirect_pc18=32'h0000_0013 -> fetch from 0x10.
- Simultaneous redirect and stall18=1 -> redirect honoured.
- RESET_PC=32'hFFFF_FFF8, no stall -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- rst18 asserted asynchronously mid-stream with a read outstanding -> outputs go to NOP/valid18=0 immediately; after release, fetch restarts at RESET_PC; stale imem_rdata18 is ignored.

Source files
------------

// File: rtl/nios2_pkg.sv
// Shared nios2 constants: instruction width, NOP encoding, reset vector, opcodes.
// No logic, so no latency.
// No flow control.
package nios2_pkg;

    localparam int               INSTR_W        = 32;
    localparam logic [INSTR_W-1:0] NIOS2_NOP    = 32'h0001883A;
    localparam logic [31:0]      NIOS2_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_BR  = 6'h06;
    localparam logic [5:0] OP_BLT = 6'h16;
    localparam logic [5:0] OP_LDW = 6'h17;
    localparam logic [5:0] OP_STW = 6'h15;

    function automatic logic [5:0] nios2_opcode(input logic [INSTR_W-1:0] ins);
        return ins[5:0];
    endfunction

endpackage

// File: rtl/nios2_fetch_if.sv
// Fetch stage bus: instruction-memory read port plus the core-side issue/redirect handshake.
// Wires only, so no latency.
// The core holds off delivery with stall18; redirect18 overrides stall18.
interface nios2_fetch_if #(parameter int ADDR_W = 32);
    import nios2_pkg::*;

    logic               imem_rd18;
    logic [ADDR_W-1:0]  imem_addr18;
    logic [INSTR_W-1:0] imem_rdata18;
    logic               stall18;
    logic               redirect18;
    logic [ADDR_W-1:0]  redirect_pc18;
    logic               valid18;
    logic [INSTR_W-1:0] instruction18;
    logic [ADDR_W-1:0]  pc18;

    modport master (
        output imem_rd18, imem_addr18, valid18, instruction18, pc18,
        input  imem_rdata18, stall18, redirect18, redirect_pc18
    );

    modport slave (
        input  imem_rd18, imem_addr18, valid18, instruction18, pc18,
        output imem_rdata18, stall18, redirect18, redirect_pc18
    );

endinterface

// File: rtl/nios2_fetch_fifo.sv
// Two-entry {pc,instr} queue; the head is a register so the core never sees a memory path.
// A pushed word reaches the head one edge after the push.
// The caller must not push when full; flush wins over push and pop.
module nios2_fetch_fifo
    import nios2_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk18,
    input  logic               rst18,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output logic [1:0]         count,
    output logic               empty,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t     e0_q, e1_q, new_e;
    logic [1:0] cnt_q;

    assign new_e = {push_pc, push_instr};

    always_ff @(posedge clk18 or posedge rst18) begin
        if (rst18) begin
            cnt_q <= 2'd0;
            e0_q  <= {RESET_PC, NIOS2_NOP};
            e1_q  <= {RESET_PC, NIOS2_NOP};
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_q <= new_e;
                    else               e1_q <= new_e;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; with two entries the tail shifts forward.
                    if (cnt_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= new_e;
                    end else begin
                        e0_q <= new_e;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = cnt_q;
    assign empty      = (cnt_q == 2'd0);
    assign head_pc    = e0_q.pc;
    assign head_instr = e0_q.instr;

endmodule

// File: rtl/nios2_fetch.sv
// Instruction fetch: sequential word reads, 2-entry buffer, redirect with wrong-path discard.
// First valid instruction 2 cycles after reset release or redirect; 1 instr/cycle sustained.
// Stall holds the head and stops issue once buffered+in-flight reaches 2; redirect overrides stall.
module nios2_fetch
    import nios2_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NIOS2_RESET_PC)
) (
    input  logic         clk18,
    input  logic         rst18,
    nios2_fetch_if.master bus
);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [1:0]         count;
    logic               empty;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         pending;

    always_comb begin
        pop     = ~empty & ~bus.stall18 & ~bus.redirect18;
        pending = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue   = ~rst18 & ~bus.redirect18 & (pending < 3'd2);
        // A redirect lands in the same cycle as the wrong-path response, so it is dropped here.
        push    = inflight & ~bus.redirect18;
    end

    always_ff @(posedge clk18 or posedge rst18) begin
        if (rst18) begin
            fetch_pc    <= {RESET_PC[ADDR_W-1:2], 2'b00};
            inflight    <= 1'b0;
            inflight_pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
        end else begin
            if (bus.redirect18)
                fetch_pc <= {bus.redirect_pc18[ADDR_W-1:2], 2'b00};
            else if (issue)
                fetch_pc <= fetch_pc + ADDR_W'(4);
            inflight <= issue;
            if (issue)
                inflight_pc <= fetch_pc;
        end
    end

    nios2_fetch_fifo #(
        .ADDR_W   (ADDR_W),
        .RESET_PC ({RESET_PC[ADDR_W-1:2], 2'b00})
    ) u_fifo (
        .clk18      (clk18),
        .rst18      (rst18),
        .flush      (bus.redirect18),
        .push       (push),
        .pop        (pop),
        .push_pc    (inflight_pc),
        .push_instr (bus.imem_rdata18),
        .count      (count),
        .empty      (empty),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign bus.imem_rd18     = issue;
    assign bus.imem_addr18   = fetch_pc;
    assign bus.valid18       = ~empty;
    assign bus.instruction18 = empty ? NIOS2_NOP : head_instr;
    assign bus.pc18          = head_pc;

endmodule

// File: tb/tb_nios2_fetch.sv
// Directed per-cycle vectors for nios2_fetch plus a second instance fetching across the address wrap.
module tb_nios2_fetch;
    import nios2_pkg::*;

    logic clk18 = 1'b0;
    logic rst18 = 1'b1;
    always #5 clk18 = ~clk18;

    nios2_fetch_if #(.ADDR_W(32)) bus_a ();
    nios2_fetch_if #(.ADDR_W(32)) bus_b ();

    nios2_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk18 (clk18),
        .rst18 (rst18),
        .bus   (bus_a)
    );

    nios2_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk18 (clk18),
        .rst18 (rst18),
        .bus   (bus_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h21000017;
        if (a == 32'h4) return 32'h000A0C7A;
        return a ^ 32'hC0DE0000;
    endfunction

    // Synchronous memories: data appears the cycle after the read and holds otherwise.
    always @(posedge clk18) if (bus_a.imem_rd18) bus_a.imem_rdata18 <= mem_word(bus_a.imem_addr18);
    always @(posedge clk18) if (bus_b.imem_rd18) bus_b.imem_rdata18 <= mem_word(bus_b.imem_addr18);

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rd;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ins;
    } row_t;

    function automatic row_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic rd, input logic [31:0] addr,
                                input logic v, input logic [31:0] pc);
        row_t x;
        x.stall = s;  x.redir = r;  x.rpc = rpc;
        x.rd    = rd; x.addr  = addr;
        x.vld   = v;  x.pc    = pc;
        x.ins   = v ? mem_word(pc) : NIOS2_NOP;
        return x;
    endfunction

    localparam int NROWS   = 26;
    localparam int RST_ROW = 23;

    row_t        rows [NROWS];
    logic [31:0] b_addr [4];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_reset_state();
        chk("rst_rd",    32'(bus_a.imem_rd18),  32'd0);
        chk("rst_valid", 32'(bus_a.valid18),    32'd0);
        chk("rst_instr", bus_a.instruction18,   NIOS2_NOP);
        chk("rst_pc",    bus_a.pc18,            32'h0000_0000);
        chk("rst_pc_b",  bus_b.pc18,            32'hFFFF_FFF8);
    endtask

    initial begin
        // Boot, 3-cycle stall at pc 4, redirect, unaligned redirect, redirect under stall,
        // back-to-back redirects, then restart after an asynchronous reset.
        rows[0]  = mk(0, 0, 0,      1, 32'h00,  0, 0);
        rows[1]  = mk(0, 0, 0,      1, 32'h04,  0, 0);
        rows[2]  = mk(0, 0, 0,      1, 32'h08,  1, 32'h00);
        rows[3]  = mk(1, 0, 0,      0, 0,       1, 32'h04);
        rows[4]  = mk(1, 0, 0,      0, 0,       1, 32'h04);
        rows[5]  = mk(1, 0, 0,      0, 0,       1, 32'h04);
        rows[6]  = mk(0, 0, 0,      1, 32'h0C,  1, 32'h04);
        rows[7]  = mk(0, 0, 0,      1, 32'h10,  1, 32'h08);
        rows[8]  = mk(0, 1, 32'h10, 0, 0,       1, 32'h0C);
        rows[9]  = mk(0, 0, 0,      1, 32'h10,  0, 0);
        rows[10] = mk(0, 0, 0,      1, 32'h14,  0, 0);
        rows[11] = mk(0, 1, 32'h13, 0, 0,       1, 32'h10);
        rows[12] = mk(0, 0, 0,      1, 32'h10,  0, 0);
        rows[13] = mk(0, 0, 0,      1, 32'h14,  0, 0);
        rows[14] = mk(1, 1, 32'h40, 0, 0,       1, 32'h10);
        rows[15] = mk(0, 0, 0,      1, 32'h40,  0, 0);
        rows[16] = mk(0, 0, 0,      1, 32'h44,  0, 0);
        rows[17] = mk(0, 0, 0,      1, 32'h48,  1, 32'h40);
        rows[18] = mk(0, 1, 32'h80, 0, 0,       1, 32'h44);
        rows[19] = mk(0, 1, 32'h104,0, 0,       0, 0);
        rows[20] = mk(0, 0, 0,      1, 32'h104, 0, 0);
        rows[21] = mk(0, 0, 0,      1, 32'h108, 0, 0);
        rows[22] = mk(0, 0, 0,      1, 32'h10C, 1, 32'h104);
        rows[23] = mk(0, 0, 0,      1, 32'h00,  0, 0);
        rows[24] = mk(0, 0, 0,      1, 32'h04,  0, 0);
        rows[25] = mk(0, 0, 0,      1, 32'h08,  1, 32'h00);

        b_addr[0] = 32'hFFFF_FFF8;
        b_addr[1] = 32'hFFFF_FFFC;
        b_addr[2] = 32'h0000_0000;
        b_addr[3] = 32'h0000_0004;

        bus_a.stall18 = 1'b0; bus_a.redirect18 = 1'b0; bus_a.redirect_pc18 = '0;
        bus_b.stall18 = 1'b0; bus_b.redirect18 = 1'b0; bus_b.redirect_pc18 = '0;

        repeat (2) @(posedge clk18);
        #1;
        chk_reset_state();

        for (int i = 0; i < NROWS; i++) begin
            @(negedge clk18);
            rst18               = 1'b0;
            bus_a.stall18       = rows[i].stall;
            bus_a.redirect18    = rows[i].redir;
            bus_a.redirect_pc18 = rows[i].rpc;
            #1;
            chk($sformatf("rd[%0d]", i),    32'(bus_a.imem_rd18), 32'(rows[i].rd));
            if (rows[i].rd)
                chk($sformatf("addr[%0d]", i), bus_a.imem_addr18, rows[i].addr);
            chk($sformatf("valid[%0d]", i), 32'(bus_a.valid18),   32'(rows[i].vld));
            chk($sformatf("instr[%0d]", i), bus_a.instruction18,  rows[i].ins);
            if (rows[i].vld)
                chk($sformatf("pc[%0d]", i), bus_a.pc18, rows[i].pc);
            if (i < 4) begin
                chk($sformatf("wrap_rd[%0d]", i),   32'(bus_b.imem_rd18), 32'd1);
                chk($sformatf("wrap_addr[%0d]", i), bus_b.imem_addr18,    b_addr[i]);
                if (i >= 2) begin
                    chk($sformatf("wrap_pc[%0d]", i),    bus_b.pc18,          b_addr[i-2]);
                    chk($sformatf("wrap_instr[%0d]", i), bus_b.instruction18, mem_word(b_addr[i-2]));
                end
            end
            @(posedge clk18);
            if (i == RST_ROW - 1) begin
                // A read is outstanding here; reset must take effect without a clock edge.
                #2;
                rst18 = 1'b1;
                #1;
                chk_reset_state();
                repeat (2) @(posedge clk18);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
